obi_traffic_master: RTL
=======================

Name: obi_traffic_master

Overview:
Parametrised OBI master that generates test traffic toward the SPI-slave OBI port. On a start pulse it issues NUM_WORDS writes, NUM_WORDS reads, or a write pass followed by a read-and-verify pass. Word addresses are BASE_ADDR + i*ADDR_STRIDE. Up to MAX_OUTSTANDING transactions may be pipelined. Mismatches on readback are counted and reported to the bench or top-level status register.

Parameters:
ADDR_WIDTH, 32, OBI address width
DATA_WIDTH, 32, OBI data width; multiple of 8
NUM_WORDS, 8, words per pass; >=1
BASE_ADDR, 32'h0000, first word address
ADDR_STRIDE, 4, byte increment between words
MAX_OUTSTANDING, 2, granted-but-unanswered transaction limit; >=1
PATTERN, 32'hA5A5_0000, data seed; zero-extended or truncated to DATA_WIDTH

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
start_i  in  1  start pulse; sampled only in IDLE
mode_i  in  2  0=write only, 1=read only, 2=write then verify, 3=reserved (treated as 2)
busy_o  out  1  high from the cycle after accepted start until DONE
done_o  out  1  one-cycle pulse at end of sequence
err_cnt_o  out  16  readback mismatch count; saturates at 16'hFFFF
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  ADDR_WIDTH  OBI address
obi_we_o  out  1  OBI write enable
obi_be_o  out  DATA_WIDTH/8  byte enable; always all ones
obi_wdata_o  out  DATA_WIDTH  OBI write data
obi_rvalid_i  in  1  OBI response valid (for reads and writes)
obi_rdata_i  in  DATA_WIDTH  OBI read data

Behaviour:
- Reset (async, rstn_i low): state IDLE; obi_req_o=0, obi_we_o=0, obi_addr_o=0, obi_wdata_o=0, obi_be_o=all ones, busy_o=0, done_o=0, err_cnt_o=0. All counters cleared. Reset mid-transfer abandons the sequence; in-flight responses after reset are ignored.
- States: IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE.
- IDLE, start_i=1: clear err_cnt_o, issue counter and response counter. mode 1 goes to READ; all other modes go to WRITE. start_i in any other state is ignored.
- Issue rule (WRITE and READ): obi_req_o=1 when issued<NUM_WORDS and outstanding<MAX_OUTSTANDING.
  - Once req is high, addr, we and wdata hold stable and req stays high until gnt.
  - Handshake completes in the cycle where req && gnt. Next index presented the following cycle; back-to-back grants allowed.
- Word i:
  - addr = BASE_ADDR + i*ADDR_STRIDE, computed modulo 2^ADDR_WIDTH (wrap allowed).
  - wdata = PATTERN ^ i, with i zero-extended.
  - we=1 in WRITE, we=0 in READ.
- Outstanding counter:
  - +1 on req&&gnt, -1 on rvalid; both in the same cycle leaves it unchanged.
  - rvalid while outstanding==0 is ignored.
- Responses are in order; response index r increments on each counted rvalid.
  - READ in mode 2: compare rdata against PATTERN^r and increment err_cnt_o on mismatch (saturating).
  - Mode 1: responses are counted but not compared.
- WRITE -> WDRAIN after NUM_WORDS grants. WDRAIN waits for NUM_WORDS responses, then:
  - mode 0 -> DONE;
  - else -> READ, with issue and response counters cleared.
- READ -> RDRAIN after NUM_WORDS grants. RDRAIN -> DONE after NUM_WORDS responses.
- DONE: done_o=1 for exactly one cycle, busy_o drops in the same cycle, then IDLE. err_cnt_o holds until the next accepted start.
- Minimum latency with gnt always high and rvalid one cycle after gnt: mode 0 takes NUM_WORDS+3 cycles from start to done.

Test Plan:
- Mode 0, NUM_WORDS=8, gnt tied high, rvalid 1 cycle after gnt -> addrs 0x00..0x1C, wdata A5A50000..A5A50007, done after 11 cycles, err=0.
- Mode 2, memory model echoing written data, random gnt/rvalid delays 0-5 cycles -> 16 handshakes, outstanding never >2, req/addr/wdata stable while gnt=0, err=0.
- Mode 2, memory corrupts words 3 and 6 -> err_cnt_o=2 at done pulse; new start clears it to 0.
- MAX_OUTSTANDING=1, rvalid delayed 4 cycles -> req low while a transaction is outstanding; gnt and rvalid in the same cycle keep the count correct.
- BASE_ADDR=32'hFFFF_FFF8, mode 1 -> addresses FFFFFFF8, FFFFFFFC, 00000000, ...; start_i pulsed while busy is ignored.
- rstn_i asserted during READ with 2 outstanding -> all outputs at reset values immediately; late rvalid ignored; next start runs a clean sequence.

Source files
------------

// File: rtl/obi_traffic_master.sv
// obi_traffic_master: OBI traffic generator for exercising the SPI-slave OBI port.
// A start pulse launches NUM_WORDS writes, NUM_WORDS reads, or a write pass
// followed by a read-and-verify pass, over addresses BASE_ADDR + i*ADDR_STRIDE.
// Up to MAX_OUTSTANDING transactions may be granted but not yet answered.
//
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   start_i            start pulse, accepted only while idle
//   mode_i             0 write, 1 read, 2/3 write then verify
//   busy_o, done_o     sequence running / one-cycle end-of-sequence pulse
//   err_cnt_o          saturating readback mismatch count
//   obi_*              OBI master request/response channel
module obi_traffic_master #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           NUM_WORDS       = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int unsigned           ADDR_STRIDE     = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [31:0]           PATTERN         = 32'hA5A5_0000
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic [1:0]              mode_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [15:0]             err_cnt_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i
);

    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(NUM_WORDS);
    localparam logic [OUT_W-1:0]      MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [DATA_WIDTH-1:0] PAT      = DATA_WIDTH'(PATTERN);
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WDRAIN,
        S_READ,
        S_RDRAIN,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [CNT_W-1:0]        issued_q, issued_d;
    logic [CNT_W-1:0]        resp_q, resp_d;
    logic [OUT_W-1:0]        outst_q, outst_d;
    logic [15:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic handshake_c;
    logic resp_accept_c;
    logic verify_phase_c;
    logic issuing_c;

    assign handshake_c    = req_q && obi_gnt_i;
    // A response with nothing in flight (e.g. left over from before a reset) is dropped.
    assign resp_accept_c  = obi_rvalid_i && (outst_q != '0);
    assign verify_phase_c = mode_q[1] && ((state_q == S_READ) || (state_q == S_RDRAIN));

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'd0;
            issued_q <= '0;
            resp_q   <= '0;
            outst_q  <= '0;
            err_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            issued_q <= issued_d;
            resp_q   <= resp_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        issued_d = issued_q;
        resp_d   = resp_q;
        outst_d  = outst_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        req_d    = 1'b0;
        we_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        issuing_c = 1'b0;

        if (handshake_c) begin
            issued_d = issued_q + CNT_W'(1);
            addr_d   = addr_q + STRIDE;
        end
        if (resp_accept_c) begin
            resp_d = resp_q + CNT_W'(1);
        end
        case ({handshake_c, resp_accept_c})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase

        // Responses return in order, so resp_q is the index of the word being answered.
        if (resp_accept_c && verify_phase_c &&
            (obi_rdata_i != (PAT ^ DATA_WIDTH'(resp_q))) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d   = mode_i;
                    issued_d = '0;
                    resp_d   = '0;
                    outst_d  = '0;
                    err_d    = '0;
                    addr_d   = BASE_ADDR;
                    state_d  = (mode_i == 2'd1) ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                if (issued_d == LAST_CNT) state_d = S_WDRAIN;
            end
            S_WDRAIN: begin
                if (resp_d == LAST_CNT) begin
                    if (mode_q == 2'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_READ;
                        issued_d = '0;
                        resp_d   = '0;
                        addr_d   = BASE_ADDR;
                    end
                end
            end
            S_READ: begin
                if (issued_d == LAST_CNT) state_d = S_RDRAIN;
            end
            S_RDRAIN: begin
                if (resp_d == LAST_CNT) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_WRITE) || (state_d == S_READ)) begin
            wdata_d = PAT ^ DATA_WIDTH'(issued_d);
        end

        // Request is raised one cycle after entering an issue phase and is held
        // until granted: without a grant issued_d is unchanged and outst_d cannot grow.
        issuing_c = ((state_q == S_WRITE) || (state_q == S_READ)) && (state_d == state_q);
        req_d     = issuing_c && (issued_d < LAST_CNT) && (outst_d < MAX_OUT);
        we_d      = (state_d == S_WRITE);
        busy_d    = (state_d == S_WRITE) || (state_d == S_WDRAIN) ||
                    (state_d == S_READ)  || (state_d == S_RDRAIN);
        done_d    = (state_d == S_DONE);
    end

    assign obi_req_o   = req_q;
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = we_q;
    assign obi_wdata_o = wdata_q;
    assign obi_be_o    = '1;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_cnt_o   = err_q;

endmodule
